gpr_access_arbiter: RTL and testbench
=====================================

# gpr_access_arbiter

Serialises access to the X/Y general-purpose register pair between up to four requesters, such as the control unit, a debug/load port and an I/O engine. Each request is one operation (write X, write Y, read X, read Y). The block arbitrates, drives the register pair's write and read strobes for exactly one cycle, and returns read data with a valid pulse and the requester ID. It sits between the requesters and `general_purpose_registers`, and is the only driver of that module's control inputs.

## Interface
- `NREQ`, default 2: number of requesters, legal 2..4.
- `DATA_W`, default 16: data width; must match the register pair.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: request per requester, level.
- `op`  in  2*NREQ: op per requester, packed, requester i at bits [2i+1:2i]. Codes: 00 = write X, 01 = write Y, 10 = read X, 11 = read Y.
- `wdata`  in  DATA_W*NREQ: write data per requester, packed.
- `gnt`  out  NREQ: one-hot acceptance pulse, one cycle.
- `rdata`  out  DATA_W: captured read value.
- `rdata_valid`  out  1: one-cycle pulse, `rdata` valid.
- `rdata_id`  out  2: requester index that owns `rdata`.
- `gpr_data_in`  out  DATA_W: drives the register pair `data_in`.
- `gpr_write_x`, `gpr_write_y`, `gpr_read_x`, `gpr_read_y`  out  1 each: register pair strobes.
- `gpr_data_out_x`, `gpr_data_out_y`  in  DATA_W: register pair read outputs.

## Operation
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - If any `req` is high, pick a winner, latch its op, wdata and index, and go to EXEC.
  - Otherwise stay in IDLE.
- Winner selection is round-robin:
  - Search starts at pointer `ptr`, ascending, wrapping from NREQ-1 to 0.
  - In DONE, `ptr` becomes (winner+1) mod NREQ.
- EXEC, exactly one cycle:
  - `gnt[winner]`=1.
  - Exactly one strobe is high, decoded from the latched op.
  - `gpr_data_in` = latched wdata on writes, 0 on reads.
  - For reads, the selected `gpr_data_out_*` is captured into `rdata` at the closing edge.
- DONE, one cycle:
  - For reads, `rdata_valid`=1 and `rdata_id`=winner.
  - Always return to IDLE.
- Requester rules:
  - A requester must hold `req`, `op` and `wdata` stable until it sees `gnt`.
  - A `req` still high after `gnt` counts as a new request.
  - A `req` dropped before `gnt` is abandoned with no side effect.
- At most one strobe is high in any cycle. All strobes and `gnt` are low in IDLE and DONE.
- `rdata` holds its last value until the next read completes. `rdata_id` is 0 except during the `rdata_valid` pulse.

## Timing
- All outputs come from registers: state and latched fields, not from `req`.
- Latency, with `req` sampled high at edge k:
  - EXEC, `gnt` and strobe occupy cycle k..k+1.
  - The register write lands at edge k+1.
  - `rdata_valid` is high in cycle k+1..k+2.
- Throughput is one operation per 3 cycles. Back-to-back requests are re-arbitrated each IDLE.
- Write-then-read ordering: a read granted after a write of the same register returns the new value. Serialisation guarantees this.
- Reset values while `rst`=0, taking effect immediately:
  - State IDLE, `ptr`=0.
  - `gnt`, all `gpr_*` strobes, `gpr_data_in`, `rdata`, `rdata_valid` and `rdata_id` are 0.
- Reset asserted during EXEC drops the strobe immediately. The operation is lost and no `rdata_valid` is issued.

## Configuration
- `GPR_ARB_PRIO0_EN` defined: requester 0 has fixed highest priority. Whenever `req[0]` is high in IDLE it wins; the others are round-robin among themselves.
- `GPR_ARB_PRIO0_EN` undefined: pure round-robin over all NREQ requesters.
- `ptr` update is identical in both cases.

## Structure
- Package `gpr_ctrl_pkg` holds:
  - `DATA_W`.
  - Op code constants: OP_WR_X, OP_WR_Y, OP_RD_X, OP_RD_Y.
  - State typedef: IDLE/EXEC/DONE.
- Sub-module `gpr_rr_pick`: combinational winner selection from `req` and `ptr`. It is the only place `GPR_ARB_PRIO0_EN` is used.
- FSM, latches and `ptr` live in `gpr_access_arbiter`.

## Test plan
- Reset with `req`=2'b11 held → no `gnt` and all strobes 0 while `rst`=0. After release, first `gnt`=2'b01 (`ptr`=0).
- Requester 0 writes X=16'hA5A5, then requester 1 reads X → `gpr_write_x` pulses 1 cycle; later `rdata`=16'hA5A5, `rdata_id`=1, `rdata_valid` 1 cycle, 5 cycles after the read `req` when it waits out the write.
- Both requesters hold `req` continuously with reads → `gnt` alternates 01,10,01,10, one grant every 3 cycles (round-robin). With `GPR_ARB_PRIO0_EN` → `gnt` stays 01.
- Write Y=16'h5A5A, then read Y and read X with X never written → `rdata` = 16'h5A5A, then 16'h0000.
- Assert `rst` during an EXEC write of X=16'h1234 → strobe drops same cycle. A subsequent read X returns 16'h0000 (register pair also reset).
- NREQ=4, only `req[3]` high with `ptr`=0 → wrap search grants 4'b1000; next `ptr`=0.

Source files
------------

// File: rtl/gpr_ctrl_pkg.sv
// Shared definitions for the X/Y general-purpose register access path.
//   DATA_W      : default register data width
//   OP_*        : per-requester operation codes (write X/Y, read X/Y)
//   gpr_state_e : arbiter FSM states
//   rr_add      : modular index step used by round-robin search and pointer update
package gpr_ctrl_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] OP_WR_X = 2'b00;
  localparam logic [1:0] OP_WR_Y = 2'b01;
  localparam logic [1:0] OP_RD_X = 2'b10;
  localparam logic [1:0] OP_RD_Y = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } gpr_state_e;

  // (base + k) mod n, for base < n and k <= n.
  function automatic logic [1:0] rr_add(input logic [1:0] base, input int k, input int n);
    int s;
    s = int'(base) + k;
    if (s >= n) s = s - n;
    return 2'(s);
  endfunction

endpackage

// File: rtl/gpr_rr_pick.sv
// Combinational round-robin winner selection.
// Build option: GPR_ARB_PRIO0_EN -- when defined, requester 0 always wins
// while it requests; the remaining requesters share round-robin order.
// Ports:
//   i_req [NREQ] : pending requests
//   i_ptr [2]    : requester index where the search starts
//   o_any        : at least one request pending
//   o_idx [2]    : winning requester index (0 when o_any is low)
module gpr_rr_pick
  import gpr_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic            o_any,
  output logic [1:0]      o_idx
);

  logic [3:0] w_req;

  always_comb begin
    w_req = '0;
    w_req[NREQ-1:0] = i_req;
`ifdef GPR_ARB_PRIO0_EN
    // Collapsing the request set to requester 0 alone makes it win
    // regardless of where the pointer starts the search.
    if (i_req[0]) w_req = 4'b0001;
`endif
  end

  // Walk the search order backwards so the last hit written is the first
  // requester found when ascending from i_ptr.
  always_comb begin
    o_any = |w_req;
    o_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_req[rr_add(i_ptr, k, NREQ)]) o_idx = rr_add(i_ptr, k, NREQ);
    end
  end

endmodule

// File: rtl/gpr_access_arbiter.sv
// Serialises single-operation accesses from up to four requesters onto the
// X/Y general-purpose register pair and returns read data tagged with the
// requester index. Each operation takes IDLE -> EXEC -> DONE (3 cycles).
// Build option: GPR_ARB_PRIO0_EN (see gpr_rr_pick) gives requester 0 fixed
// top priority; default build is pure round-robin.
// Ports:
//   clk, rst (async, active-low)
//   req[NREQ], op[2*NREQ], wdata[DATA_W*NREQ] : requester side, held until gnt
//   gnt[NREQ]                                 : one-hot acceptance pulse (EXEC)
//   rdata, rdata_valid, rdata_id              : read return (valid in DONE)
//   gpr_data_in, gpr_write_x/y, gpr_read_x/y  : register pair controls
//   gpr_data_out_x/y                          : register pair read values
module gpr_access_arbiter
  import gpr_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = gpr_ctrl_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [DATA_W*NREQ-1:0] wdata,
  output logic [NREQ-1:0]        gnt,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rdata_valid,
  output logic [1:0]             rdata_id,
  output logic [DATA_W-1:0]      gpr_data_in,
  output logic                   gpr_write_x,
  output logic                   gpr_write_y,
  output logic                   gpr_read_x,
  output logic                   gpr_read_y,
  input  logic [DATA_W-1:0]      gpr_data_out_x,
  input  logic [DATA_W-1:0]      gpr_data_out_y
);

  gpr_state_e        r_state;
  gpr_state_e        w_state_nxt;
  logic [1:0]        r_op;
  logic [1:0]        r_idx;
  logic [1:0]        r_ptr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_any;
  logic [1:0]        w_win;
  logic [1:0]        w_op_arr [4];
  logic [DATA_W-1:0] w_wd_arr [4];

  // Unpack per-requester fields into fixed 4-entry arrays so the winner
  // index can select them directly for any NREQ.
  for (genvar g = 0; g < 4; g++) begin : g_unpack
    if (g < NREQ) begin : g_used
      assign w_op_arr[g] = op[2*g +: 2];
      assign w_wd_arr[g] = wdata[DATA_W*g +: DATA_W];
    end else begin : g_unused
      assign w_op_arr[g] = '0;
      assign w_wd_arr[g] = '0;
    end
  end

  gpr_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_win)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Outputs decode only from state and latched fields, never from req.
  always_comb begin
    w_state_nxt = r_state;
    gnt         = '0;
    gpr_data_in = '0;
    gpr_write_x = 1'b0;
    gpr_write_y = 1'b0;
    gpr_read_x  = 1'b0;
    gpr_read_y  = 1'b0;
    rdata_valid = 1'b0;
    rdata_id    = 2'd0;
    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = EXEC;
      end
      EXEC: begin
        w_state_nxt = DONE;
        gnt = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;
        case (r_op)
          OP_WR_X: begin
            gpr_write_x = 1'b1;
            gpr_data_in = r_wdata;
          end
          OP_WR_Y: begin
            gpr_write_y = 1'b1;
            gpr_data_in = r_wdata;
          end
          OP_RD_X: gpr_read_x = 1'b1;
          OP_RD_Y: gpr_read_y = 1'b1;
          default: ;
        endcase
      end
      DONE: begin
        w_state_nxt = IDLE;
        if (r_op[1]) begin
          rdata_valid = 1'b1;
          rdata_id    = r_idx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_op    <= w_op_arr[w_win];
        r_wdata <= w_wd_arr[w_win];
        r_idx   <= w_win;
      end
      // Read value is taken at the edge that closes EXEC; it then holds
      // until the next read completes.
      if (r_state == EXEC && r_op[1]) begin
        r_rdata <= r_op[0] ? gpr_data_out_y : gpr_data_out_x;
      end
      if (r_state == DONE) r_ptr <= rr_add(r_idx, 1, NREQ);
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_gpr_access_arbiter.sv
module tb_gpr_access_arbiter;
  import gpr_ctrl_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [DW*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     rdata;
  logic              rdata_valid;
  logic [1:0]        rdata_id;
  logic [DW-1:0]     gpr_data_in;
  logic              gpr_write_x, gpr_write_y, gpr_read_x, gpr_read_y;
  logic [DW-1:0]     gpr_data_out_x, gpr_data_out_y;

  always #5 clk = ~clk;

  gpr_access_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .op             (op),
    .wdata          (wdata),
    .gnt            (gnt),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .rdata_id       (rdata_id),
    .gpr_data_in    (gpr_data_in),
    .gpr_write_x    (gpr_write_x),
    .gpr_write_y    (gpr_write_y),
    .gpr_read_x     (gpr_read_x),
    .gpr_read_y     (gpr_read_y),
    .gpr_data_out_x (gpr_data_out_x),
    .gpr_data_out_y (gpr_data_out_y)
  );

  // Register pair model: reset with the arbiter, written at the edge closing EXEC.
  logic [DW-1:0] m_x, m_y;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_x <= '0;
      m_y <= '0;
    end else begin
      if (gpr_write_x) m_x <= gpr_data_in;
      if (gpr_write_y) m_y <= gpr_data_in;
    end
  end
  assign gpr_data_out_x = m_x;
  assign gpr_data_out_y = m_y;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard: grant/strobe expectations and read-return expectations.
  typedef struct packed {
    logic [3:0]    g;
    logic [3:0]    s;
    logic [DW-1:0] d;
  } gexp_t;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    id;
  } rexp_t;
  gexp_t g_q[$];
  rexp_t r_q[$];
  logic [DW-1:0] sx = '0, sy = '0;   // shadow register contents in grant order

  task automatic push_op(input int r, input logic [1:0] o, input logic [DW-1:0] d);
    gexp_t g;
    rexp_t e;
    g.g = 4'b0001 << r;
    g.s = 4'b0001 << o;
    g.d = o[1] ? '0 : d;
    g_q.push_back(g);
    if (o == OP_WR_X) sx = d;
    if (o == OP_WR_Y) sy = d;
    if (o[1]) begin
      e.d  = o[0] ? sy : sx;
      e.id = 2'(r);
      r_q.push_back(e);
    end
  endtask

  // Monitor: compares DUT activity against the scoreboard away from the clock edge.
  logic [3:0] m_strb;
  gexp_t      m_g;
  rexp_t      m_r;
  always @(negedge clk) begin
    if (rst) begin
      m_strb = {gpr_read_y, gpr_read_x, gpr_write_y, gpr_write_x};
      if (gnt != '0 || m_strb != '0) begin
        if (g_q.size() == 0) check_val("unexp_gnt", {gnt, m_strb}, 0);
        else begin
          m_g = g_q.pop_front();
          check_val("gnt", gnt, m_g.g);
          check_val("strobe", m_strb, m_g.s);
          check_val("din", gpr_data_in, m_g.d);
        end
      end else if (gpr_data_in != '0) check_val("din_idle", gpr_data_in, 0);
      if ($countones(m_strb) > 1) check_val("one_strobe", m_strb, m_g.s);
      if (rdata_valid) begin
        if (r_q.size() == 0) check_val("unexp_valid", rdata_valid, 0);
        else begin
          m_r = r_q.pop_front();
          check_val("rdata", rdata, m_r.d);
          check_val("rdata_id", rdata_id, m_r.id);
        end
      end else if (rdata_id != 2'd0) check_val("id_idle", rdata_id, 0);
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_gnt"}, gnt, 0);
    check_val({tag, "_strb"}, {gpr_read_y, gpr_read_x, gpr_write_y, gpr_write_x}, 0);
    check_val({tag, "_out"}, {rdata, rdata_valid, rdata_id, gpr_data_in}, 0);
  endtask

  // Single requester, arbiter idle: grant expected on the 2nd falling edge.
  task automatic issue(input int r, input logic [1:0] o, input logic [DW-1:0] d);
    int n;
    push_op(r, o, d);
    @(posedge clk); #1;
    op[2*r +: 2]     = o;
    wdata[DW*r +: DW] = d;
    req[r]           = 1'b1;
    n = 0;
    while (!gnt[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("gnt_lat", n, 2);
    req[r] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Requesters 0 and 1 raised together (requester 0 expected first);
  // o1 must be a read. Returns the falling-edge count to its rdata_valid.
  task automatic issue2(input logic [1:0] o0, input logic [1:0] o1,
                        input logic [DW-1:0] d0, input int exp_lat);
    int n, nv, need;
    push_op(0, o0, d0);
    push_op(1, o1, '0);
    need = o0[1] ? 2 : 1;
    @(posedge clk); #1;
    op[1:0] = o0; op[3:2] = o1;
    wdata[DW-1:0] = d0;
    req[1:0] = 2'b11;
    n = 0; nv = 0;
    while (nv < need && n < 30) begin
      @(negedge clk);
      n++;
      if (gnt[0]) req[0] = 1'b0;
      if (gnt[1]) req[1] = 1'b0;
      if (rdata_valid) nv++;
    end
    check_val("rd_lat", n, exp_lat);
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gc[4];
    int k, n;
    rst   = 1'b0;
    req   = 4'b0011;
    op    = {2'b00, 2'b00, OP_RD_X, OP_RD_X};
    wdata = '0;

    // Reset held with requests pending: nothing may be granted.
    repeat (3) begin
      @(negedge clk);
      check_reset_outputs("rst_hold");
    end

    // Both requesters read X continuously: alternate, one grant per 3 cycles.
    for (int i = 0; i < 4; i++) begin
`ifdef GPR_ARB_PRIO0_EN
      push_op(0, OP_RD_X, '0);
`else
      push_op(i % 2, OP_RD_X, '0);
`endif
    end
    rst = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt != '0) begin
        gc[k] = cyc;
        k++;
      end
    end
    req = '0;
    check_val("alt_count", k, 4);
    for (int i = 1; i < 4; i++) check_val("alt_gap", gc[i] - gc[i-1], 3);
    repeat (3) @(negedge clk);

    // Write X by 0 then read X by 1, requested together.
    issue2(OP_WR_X, OP_RD_X, 16'hA5A5, 6);
    repeat (2) @(negedge clk);

    // Write Y, check rdata holds, read Y and X back.
    issue(0, OP_WR_Y, 16'h5A5A);
    check_val("rdata_hold", rdata, 16'hA5A5);
    issue(1, OP_RD_Y, '0);
    issue(1, OP_RD_X, '0);

    // Reset in the middle of an EXEC write of X.
    @(posedge clk); #1;
    op[1:0] = OP_WR_X; wdata[DW-1:0] = 16'h1234; req[0] = 1'b1;
    @(posedge clk); #2;
    check_val("exec_wx", {gpr_write_x, gpr_data_in, gnt}, {1'b1, 16'h1234, 4'b0001});
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_exec");
    req = 4'b1111;
    @(negedge clk);
    check_reset_outputs("rst_exec_hold");
    req = '0;
    sx = '0; sy = '0;
    @(negedge clk);
    rst = 1'b1;

    // Only requester 3 with pointer 0: wrap search, then pointer returns to 0.
    issue(3, OP_RD_X, '0);
    issue2(OP_RD_Y, OP_RD_X, '0, 6);
    repeat (3) @(negedge clk);

    check_val("gq_left", g_q.size(), 0);
    check_val("rq_left", r_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
